tt_ctrl_spine: RTL and testbench

- Spine-side controller at the foot of the vertical spine; it is the driving end of the row mux interface.
- Synchronises the three external control pins (select-reset, select-increment, enable) and maintains the 10-bit module select address.
- Packs address, enable and user inputs onto spine_iw; unpacks spine_ow back to user outputs.
- Sequences enable around every address change, so that no row/column decoder ever sees an address change while enable is high.

---
 rtl/tt_ctrl_spine.sv | 190 +++++++++++++++++++
 tb/tb_tt_ctrl_spine.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_ctrl_spine.sv
// tt_ctrl_spine: spine-side controller at the foot of the vertical spine.
// Synchronises the external select/enable pins, owns the 10-bit module
// select address, and drives the packed row mux bus. Enable is always
// dropped for a full cycle before the address moves and held low for a
// guard period afterwards, so no decoder ever sees the address change
// while enable is high.

`ifndef TT_N_IO
`define TT_N_IO 8
`endif
`ifndef TT_N_O
`define TT_N_O 8
`endif
`ifndef TT_N_I
`define TT_N_I 10
`endif

module tt_ctrl_spine #(
  parameter int N_IO         = `TT_N_IO,
  parameter int N_O          = `TT_N_O,
  parameter int N_I          = `TT_N_I,
  parameter int SYNC_STAGES  = 2,
  parameter int GUARD_CYCLES = 4,
  parameter int S_OW         = N_O + N_IO*2 + 2,
  parameter int S_IW         = N_I + N_IO + 13,
  parameter int U_OW         = N_O + N_IO*2,
  parameter int U_IW         = N_I + N_IO
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ctrl_sel_rst_n,
  input  logic            ctrl_sel_inc,
  input  logic            ctrl_ena,
  input  logic [U_IW-1:0] usr_iw,
  output logic [U_OW-1:0] usr_ow,
  output logic [S_IW-1:0] spine_iw,
  input  logic [S_OW-1:0] spine_ow,
  output logic [9:0]      sel_cur,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_SETTLE = 2'd1,
    S_RUN    = 2'd2,
    S_DROP   = 2'd3
  } state_t;

  localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES);

  // Synchroniser chains; a cleared chain reads as select-reset asserted.
  logic [SYNC_STAGES-1:0] r_sync_rst;
  logic [SYNC_STAGES-1:0] r_sync_inc;
  logic [SYNC_STAGES-1:0] r_sync_ena;
  logic                   r_inc_prev;

  logic w_sel_rst_s;
  logic w_inc_s;
  logic w_ena_s;
  logic w_inc_edge;

  // Controller state and its registered datapath.
  state_t     r_state;
  logic [9:0] r_sel;
  logic       r_ena;
  logic [3:0] r_guard;
  logic       r_pending;

  state_t     w_state_nxt;
  logic [9:0] w_sel_nxt;
  logic       w_ena_nxt;
  logic [3:0] w_guard_nxt;
  logic       w_pending_nxt;
  logic       w_pend_merged;

  // Guard bits on the outward bus carry no user data.
  logic w_unused_guards;

  assign w_sel_rst_s = r_sync_rst[SYNC_STAGES-1];
  assign w_inc_s     = r_sync_inc[SYNC_STAGES-1];
  assign w_ena_s     = r_sync_ena[SYNC_STAGES-1];
  assign w_inc_edge  = w_inc_s & ~r_inc_prev;

  // Shift the async pins through the synchroniser chains and keep the
  // previous synchronised increment level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync_rst <= '0;
      r_sync_inc <= '0;
      r_sync_ena <= '0;
      r_inc_prev <= 1'b0;
    end else begin
      r_sync_rst <= {r_sync_rst[SYNC_STAGES-2:0], ctrl_sel_rst_n};
      r_sync_inc <= {r_sync_inc[SYNC_STAGES-2:0], ctrl_sel_inc};
      r_sync_ena <= {r_sync_ena[SYNC_STAGES-2:0], ctrl_ena};
      r_inc_prev <= w_inc_s;
    end
  end

  // State register together with the select, enable, guard and pending
  // registers it sequences.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_HOLD;
      r_sel     <= 10'd0;
      r_ena     <= 1'b0;
      r_guard   <= 4'd0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel     <= w_sel_nxt;
      r_ena     <= w_ena_nxt;
      r_guard   <= w_guard_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Next-state logic: select-reset overrides everything; otherwise walk
  // HOLD -> SETTLE -> RUN, detouring through DROP for every increment.
  always_comb begin
    w_state_nxt   = r_state;
    w_sel_nxt     = r_sel;
    w_ena_nxt     = r_ena;
    w_guard_nxt   = r_guard;
    w_pending_nxt = r_pending;
    w_pend_merged = r_pending | w_inc_edge;

    if (!w_sel_rst_s) begin
      w_state_nxt   = S_HOLD;
      w_sel_nxt     = 10'd0;
      w_ena_nxt     = 1'b0;
      w_guard_nxt   = 4'd0;
      w_pending_nxt = 1'b0;
    end else begin
      case (r_state)
        S_HOLD: begin
          w_sel_nxt     = 10'd0;
          w_ena_nxt     = 1'b0;
          w_pending_nxt = 1'b0;
          w_guard_nxt   = GUARD_LOAD;
          w_state_nxt   = S_SETTLE;
        end
        S_SETTLE: begin
          w_ena_nxt     = 1'b0;
          w_pending_nxt = w_pend_merged;
          if (r_guard <= 4'd1) begin
            w_guard_nxt = 4'd0;
            w_state_nxt = S_RUN;
            w_ena_nxt   = w_pend_merged ? 1'b0 : w_ena_s;
          end else begin
            w_guard_nxt = r_guard - 4'd1;
          end
        end
        S_RUN: begin
          if (w_pend_merged) begin
            w_ena_nxt     = 1'b0;
            w_pending_nxt = 1'b0;
            w_state_nxt   = S_DROP;
          end else begin
            w_ena_nxt = w_ena_s;
          end
        end
        S_DROP: begin
          w_ena_nxt     = 1'b0;
          w_pending_nxt = w_pend_merged;
          w_sel_nxt     = r_sel + 10'd1;
          w_guard_nxt   = GUARD_LOAD;
          w_state_nxt   = S_SETTLE;
        end
        default: begin
          w_state_nxt   = S_HOLD;
          w_sel_nxt     = 10'd0;
          w_ena_nxt     = 1'b0;
          w_guard_nxt   = 4'd0;
          w_pending_nxt = 1'b0;
        end
      endcase
    end
  end

  // Outputs: status flags plus the flop-free bus packing and unpacking.
  always_comb begin
    busy            = (r_state != S_RUN);
    sel_cur         = r_sel;
    spine_iw        = {1'b0, usr_iw, r_sel, r_ena, 1'b0};
    usr_ow          = spine_ow[S_OW-2:1];
    w_unused_guards = spine_ow[0] ^ spine_ow[S_OW-1];
  end

endmodule

// File: tb/tb_tt_ctrl_spine.sv
// tb_tt_ctrl_spine: directed checks of the spine controller sequencing,
// select wrap, select-reset priority and bus pass-through.

module tb_tt_ctrl_spine;

  localparam int N_IO = 8;
  localparam int N_O  = 8;
  localparam int N_I  = 10;
  localparam int S_OW = N_O + N_IO*2 + 2;
  localparam int S_IW = N_I + N_IO + 13;
  localparam int U_OW = N_O + N_IO*2;
  localparam int U_IW = N_I + N_IO;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ctrl_sel_rst_n;
  logic            ctrl_sel_inc;
  logic            ctrl_ena;
  logic [U_IW-1:0] usr_iw;
  logic [U_OW-1:0] usr_ow;
  logic [S_IW-1:0] spine_iw;
  logic [S_OW-1:0] spine_ow;
  logic [9:0]      sel_cur;
  logic            busy;

  int vectorCount = 0;
  int missCount   = 0;

  tt_ctrl_spine #(
    .N_IO(N_IO), .N_O(N_O), .N_I(N_I),
    .SYNC_STAGES(2), .GUARD_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ctrl_sel_rst_n(ctrl_sel_rst_n),
    .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_ena(ctrl_ena),
    .usr_iw(usr_iw),
    .usr_ow(usr_ow),
    .spine_iw(spine_iw),
    .spine_ow(spine_ow),
    .sel_cur(sel_cur),
    .busy(busy)
  );

  // Free-running controller clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports misses.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Set the three control pins, then advance the given number of edges,
  // returning on the falling edge so outputs are sampled mid-cycle.
  task automatic applyStimulus(input logic selRstN, input logic inc,
                               input logic ena, input int cycles);
    ctrl_sel_rst_n = selRstN;
    ctrl_sel_inc   = inc;
    ctrl_ena       = ena;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Check select address (port and spine field), spine enable and busy.
  task automatic expectSpine(input string tag, input logic [9:0] expSel,
                             input logic expEna, input logic expBusy);
    checkOutput({tag, ".sel"},  64'(sel_cur),        64'(expSel));
    checkOutput({tag, ".fld"},  64'(spine_iw[11:2]), 64'(expSel));
    checkOutput({tag, ".ena"},  64'(spine_iw[1]),    64'(expEna));
    checkOutput({tag, ".busy"}, 64'(busy),           64'(expBusy));
  endtask

  // One-cycle increment pulse followed by enough idle time to return to RUN.
  task automatic incPulse();
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 11);
  endtask

  logic [S_IW-1:0] expIw;

  initial begin
    rst_n          = 1'b0;
    ctrl_sel_rst_n = 1'b1;
    ctrl_sel_inc   = 1'b0;
    ctrl_ena       = 1'b1;
    usr_iw         = '0;
    spine_ow       = '0;

    // Reset and boot: two HOLD cycles, four SETTLE cycles, then RUN.
    applyStimulus(1'b1, 1'b0, 1'b1, 3);
    expectSpine("reset", 10'd0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1);
      expectSpine($sformatf("boot%0d", i), 10'd0, 1'b0, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("boot_run", 10'd0, 1'b1, 1'b0);

    // Enable follows the pin through the synchroniser plus one register.
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    expectSpine("enaoff_wait", 10'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    expectSpine("enaoff", 10'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    expectSpine("enaon_wait", 10'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("enaon", 10'd0, 1'b1, 1'b0);

    // Single increment: ena low at +3, sel+1 at +4, ena back at +8.
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    expectSpine("inc1_e1", 10'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("inc1_e2", 10'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("inc1_drop", 10'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("inc1_sel", 10'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 3);
    expectSpine("inc1_settle", 10'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("inc1_run", 10'd1, 1'b1, 1'b0);

    // Select-reset back to zero before the pending-increment test.
    applyStimulus(1'b0, 1'b0, 1'b1, 3);
    expectSpine("srst_hold", 10'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 6);
    expectSpine("srst_settle", 10'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("srst_run", 10'd0, 1'b1, 1'b0);

    // Two pulses two cycles apart, third pulse discarded while pending.
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    expectSpine("dbl_drop", 10'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("dbl_sel1", 10'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("dbl_pend", 10'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("dbl_settle", 10'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("dbl_runpend", 10'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("dbl_drop2", 10'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("dbl_sel2", 10'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 3);
    expectSpine("dbl_settle2", 10'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("dbl_run", 10'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 10);
    expectSpine("dbl_final", 10'd2, 1'b1, 1'b0);

    // Walk the address up to 1023, then wrap with the full sequence.
    for (int i = 0; i < 1021; i++) incPulse();
    expectSpine("wrap_pre", 10'd1023, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 2);
    expectSpine("wrap_drop", 10'd1023, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("wrap_sel", 10'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 3);
    expectSpine("wrap_settle", 10'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("wrap_run", 10'd0, 1'b1, 1'b0);

    // Select-reset mid-SETTLE with an increment pending.
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    expectSpine("mid_sel1", 10'd1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2);
    expectSpine("mid_presync", 10'd1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    expectSpine("mid_hold", 10'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 3);
    end
    expectSpine("mid_heldinc", 10'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 12);
    expectSpine("mid_release", 10'd0, 1'b1, 1'b0);

    // Combinational pass-through in both directions, guards stripped.
    usr_iw   = 18'h002A5;
    spine_ow = {1'b1, 24'h5A3C96, 1'b1};
    #1;
    expIw = {1'b0, 18'h002A5, 10'd0, 1'b1, 1'b0};
    checkOutput("pass_usr_ow", 64'(usr_ow), 64'h5A3C96);
    checkOutput("pass_usr_fld", 64'(spine_iw[29:12]), 64'h2A5);
    checkOutput("pass_spine_iw", 64'(spine_iw), 64'(expIw));
    usr_iw   = 18'h3FFFF;
    spine_ow = {1'b0, 24'hA5C369, 1'b0};
    #1;
    expIw = {1'b0, 18'h3FFFF, 10'd0, 1'b1, 1'b0};
    checkOutput("pass_usr_ow2", 64'(usr_ow), 64'hA5C369);
    checkOutput("pass_spine_iw2", 64'(spine_iw), 64'(expIw));
    applyStimulus(1'b1, 1'b0, 1'b1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
